command_issuer: RTL

COMMAND_ISSUER -- requirements
Module: command_issuer

---
 rtl/command_issuer_if.sv | 49 ++++
 rtl/command_issuer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/command_issuer_if.sv
// Host / ALU-side signal bundle for command_issuer.
//
// master : the environment (host command source, ALU result source, result consumer)
// slave  : command_issuer itself
//
// Signals:
//   cmd_in[11:0]   host command {opcode, addr1, addr2, addr3}
//   cmd_valid      host command valid
//   cmd_ready      FIFO has room for a command
//   command[11:0]  command currently presented to the controller stage
//   syscall        one-cycle RUN strobe to the controller stage
//   y[31:0]        ALU/controller result
//   O, C, Z, N     ALU overflow, carry, zero, negative flags
//   res_data[31:0] captured result
//   res_flags[3:0] captured flags {O,C,Z,N}
//   res_valid      result available to host
//   res_ready      host accepts the result
//   fifo_count     number of queued commands
interface command_issuer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [11:0]     cmd_in;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [11:0]     command;
    logic            syscall;
    logic [31:0]     y;
    logic            O;
    logic            C;
    logic            Z;
    logic            N;
    logic [31:0]     res_data;
    logic [3:0]      res_flags;
    logic            res_valid;
    logic            res_ready;
    logic [CntW-1:0] fifo_count;

    modport master (
        output cmd_in, cmd_valid, y, O, C, Z, N, res_ready,
        input  cmd_ready, command, syscall, res_data, res_flags, res_valid, fifo_count
    );

    modport slave (
        input  cmd_in, cmd_valid, y, O, C, Z, N, res_ready,
        output cmd_ready, command, syscall, res_data, res_flags, res_valid, fifo_count
    );
endinterface

// File: rtl/command_issuer.sv
// Command issuer: queues host commands in a small FIFO and issues them one at a
// time to a controller stage. Each issue pulses syscall for one cycle, waits a
// fixed settle time (longer for CAS, opcode 3'b111), captures the ALU result and
// flags, and holds them until the host accepts.
//
// Ports:
//   clk     sole clock, rising edge
//   rst_n   asynchronous active-low reset; clears FIFO, FSM and result
//   bus_io  command_issuer_if.slave (command, controller and result signals)
//
// Parameters:
//   DEPTH      FIFO entries, power of 2, >= 2
//   SETTLE     wait cycles after a non-CAS command, >= 1
//   CAS_SETTLE wait cycles after a CAS command, >= 1
module command_issuer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned CAS_SETTLE = 4
) (
    input logic              clk,
    input logic              rst_n,
    command_issuer_if.slave  bus_io
);

    localparam int unsigned PtrW      = $clog2(DEPTH);
    localparam int unsigned CntW      = PtrW + 1;
    localparam int unsigned MaxSettle = (CAS_SETTLE > SETTLE) ? CAS_SETTLE : SETTLE;
    localparam int unsigned WaitW     = $clog2(MaxSettle + 1);
    localparam logic [2:0]  OpCas     = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResult
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [11:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;
    logic            cmd_ready;
    logic            push;
    logic            pop;

    // FSM state
    state_e          state_q;
    logic [11:0]     command_q;
    logic            syscall_q;
    logic [WaitW-1:0] wait_q;
    logic [31:0]     res_data_q;
    logic [3:0]      res_flags_q;
    logic            res_valid_q;

    // Ready comes only from registered count; a full FIFO refuses a push even
    // when a pop happens in the same cycle.
    assign cmd_ready = (count_q < CntW'(DEPTH));
    assign push      = bus_io.cmd_valid && cmd_ready;
    assign pop       = (state_q == StIdle) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Storage carries no reset: entries are only readable once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus_io.cmd_in;
        end
    end

    // DEPTH is a power of 2, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM: IDLE -> ISSUE -> WAIT (n cycles) -> RESULT -> IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            command_q   <= '0;
            syscall_q   <= 1'b0;
            wait_q      <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_valid_q <= 1'b0;
        end else begin
            // syscall is high only in the cycle the FSM sits in ISSUE.
            syscall_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        command_q <= mem_q[rd_ptr_q];
                        syscall_q <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    wait_q  <= (command_q[11:9] == OpCas) ? WaitW'(CAS_SETTLE) : WaitW'(SETTLE);
                    state_q <= StWait;
                end
                StWait: begin
                    // The edge ending the last wait cycle captures the result.
                    if (wait_q == WaitW'(1)) begin
                        res_data_q  <= bus_io.y;
                        res_flags_q <= {bus_io.O, bus_io.C, bus_io.Z, bus_io.N};
                        res_valid_q <= 1'b1;
                        state_q     <= StResult;
                    end else begin
                        wait_q <= wait_q - WaitW'(1);
                    end
                end
                StResult: begin
                    // res_valid is always 1 here, so res_ready alone completes.
                    if (bus_io.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_io.cmd_ready  = cmd_ready;
    assign bus_io.command    = command_q;
    assign bus_io.syscall    = syscall_q;
    assign bus_io.res_data   = res_data_q;
    assign bus_io.res_flags  = res_flags_q;
    assign bus_io.res_valid  = res_valid_q;
    assign bus_io.fifo_count = count_q;

endmodule
